// File: rtl/accumulator_drain.sv
// -----------------------------------------------------------------------------
// accumulator_drain
//
// Read-side controller for the partial-sum accumulator memory. A start pulse
// walks a programmed, wrapping range of accumulator addresses, issues one
// read per cycle while buffer credit allows, requantizes each returned
// partial sum (arithmetic right shift, optional ReLU, saturation) and streams
// the results over a valid/ready interface. A 2-entry output buffer absorbs
// the accumulator's 1-cycle read latency so backpressure never loses data.
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   start            begin a drain (ignored while busy)
//   base_addr        first accumulator address of the drain
//   count            number of entries to read, 0..DEPTH
//   shift            arithmetic right-shift amount
//   relu_en          clamp negative results to zero
//   Acc_Rd_en        accumulator read enable
//   Acc_Rd_Addr      accumulator read address (holds when not reading)
//   Partial_Sum_out  registered accumulator read data, valid 1 cycle later
//   out_valid        output beat valid
//   out_ready        consumer accepts the beat
//   out_data         signed requantized value
//   out_addr         source accumulator address of the beat
//   out_last         final beat of the drain
//   busy             drain in progress
//   done             1-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module accumulator_drain #(
    parameter int SIZE              = 8,
    parameter int PARTIAL_SUM_WIDTH = ((8 * 4) + 4) + SIZE + 1,
    parameter int DEPTH             = 8,
    parameter int ADDR_WIDTH        = $clog2(DEPTH),
    parameter int OUT_WIDTH         = 8,
    parameter int SHIFT_WIDTH       = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_addr,
    input  logic [ADDR_WIDTH:0]          count,
    input  logic [SHIFT_WIDTH-1:0]       shift,
    input  logic                         relu_en,
    output logic                         Acc_Rd_en,
    output logic [ADDR_WIDTH-1:0]        Acc_Rd_Addr,
    input  logic [PARTIAL_SUM_WIDTH-1:0] Partial_Sum_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_WIDTH-1:0]         out_data,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    localparam int PSW = PARTIAL_SUM_WIDTH;

    // Saturation bounds expressed at full partial-sum width.
    localparam logic signed [PSW-1:0] SAT_MAX =
        {{(PSW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [PSW-1:0] SAT_MIN =
        {{(PSW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] CNT_ZERO = {(ADDR_WIDTH + 1){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Shift, ReLU and saturate one partial sum down to OUT_WIDTH bits.
    function automatic logic [OUT_WIDTH-1:0] requant(
        input logic signed [PSW-1:0]   ps,
        input logic [SHIFT_WIDTH-1:0]  sh,
        input logic                    relu
    );
        logic signed [PSW-1:0] s;
        // A shift at or beyond the operand width leaves only the sign.
        if ({{(32 - SHIFT_WIDTH){1'b0}}, sh} >= PSW) begin
            s = {PSW{ps[PSW-1]}};
        end else begin
            s = ps >>> sh;
        end
        if (relu && s[PSW-1]) begin
            s = {PSW{1'b0}};
        end else begin
            s = s;
        end
        if (s > SAT_MAX) begin
            s = SAT_MAX;
        end else if (s < SAT_MIN) begin
            s = SAT_MIN;
        end else begin
            s = s;
        end
        return s[OUT_WIDTH-1:0];
    endfunction

    // Control and configuration registers.
    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH:0]     count_q;
    logic [SHIFT_WIDTH-1:0]  shift_q;
    logic                    relu_q;
    logic [ADDR_WIDTH:0]     issued_q;
    logic [ADDR_WIDTH-1:0]   last_addr_q;
    logic                    busy_q;
    logic                    done_q;

    // Tag of the read currently in flight through the accumulator.
    logic                    inflight_q;
    logic [ADDR_WIDTH-1:0]   inflight_addr_q;
    logic                    inflight_last_q;

    // Two-entry output buffer: slot0 is the head and drives the outputs.
    logic                    slot0_valid_q, slot0_valid_d;
    logic [OUT_WIDTH-1:0]    slot0_data_q,  slot0_data_d;
    logic [ADDR_WIDTH-1:0]   slot0_addr_q,  slot0_addr_d;
    logic                    slot0_last_q,  slot0_last_d;
    logic                    slot1_valid_q, slot1_valid_d;
    logic [OUT_WIDTH-1:0]    slot1_data_q,  slot1_data_d;
    logic [ADDR_WIDTH-1:0]   slot1_addr_q,  slot1_addr_d;
    logic                    slot1_last_q,  slot1_last_d;

    // Combinational helpers.
    logic                    pop_s;
    logic [1:0]              occ_after_pop_s;
    logic                    credit_s;
    logic                    rd_en_s;
    logic [ADDR_WIDTH-1:0]   rd_addr_s;
    logic                    rd_last_s;
    logic [OUT_WIDTH-1:0]    push_data_s;
    logic                    drain_done_s;

    // Read-issue decision: credit counts buffer entries left after this
    // cycle's pop plus the read still in flight, so pop and issue overlap.
    always_comb begin
        pop_s           = slot0_valid_q & out_ready;
        occ_after_pop_s = {1'b0, slot0_valid_q} + {1'b0, slot1_valid_q}
                        - {1'b0, pop_s};
        credit_s        = (occ_after_pop_s + {1'b0, inflight_q}) < 2'd2;
        rd_en_s         = (state_q == ST_READ) && credit_s;
        rd_addr_s       = base_q + issued_q[ADDR_WIDTH-1:0];
        rd_last_s       = (issued_q + CNT_ONE) == count_q;
        push_data_s     = requant(Partial_Sum_out, shift_q, relu_q);
    end

    // Buffer next state: pop shifts slot1 forward, then the landing read
    // fills the first free slot.
    always_comb begin
        slot0_valid_d = slot0_valid_q;
        slot0_data_d  = slot0_data_q;
        slot0_addr_d  = slot0_addr_q;
        slot0_last_d  = slot0_last_q;
        slot1_valid_d = slot1_valid_q;
        slot1_data_d  = slot1_data_q;
        slot1_addr_d  = slot1_addr_q;
        slot1_last_d  = slot1_last_q;
        if (pop_s) begin
            slot0_valid_d = slot1_valid_q;
            slot0_data_d  = slot1_data_q;
            slot0_addr_d  = slot1_addr_q;
            slot0_last_d  = slot1_last_q;
            slot1_valid_d = 1'b0;
        end else begin
            slot1_valid_d = slot1_valid_q;
        end
        if (inflight_q) begin
            if (!slot0_valid_d) begin
                slot0_valid_d = 1'b1;
                slot0_data_d  = push_data_s;
                slot0_addr_d  = inflight_addr_q;
                slot0_last_d  = inflight_last_q;
            end else begin
                slot1_valid_d = 1'b1;
                slot1_data_d  = push_data_s;
                slot1_addr_d  = inflight_addr_q;
                slot1_last_d  = inflight_last_q;
            end
        end else begin
            slot0_valid_d = slot0_valid_d;
        end
        // Nothing left in flight or buffered means the last beat is gone.
        drain_done_s = (state_q == ST_FLUSH) && !inflight_q
                     && !slot0_valid_d && !slot1_valid_d;
    end

    // FSM, read bookkeeping and buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            base_q          <= {ADDR_WIDTH{1'b0}};
            count_q         <= CNT_ZERO;
            shift_q         <= {SHIFT_WIDTH{1'b0}};
            relu_q          <= 1'b0;
            issued_q        <= CNT_ZERO;
            last_addr_q     <= {ADDR_WIDTH{1'b0}};
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= {ADDR_WIDTH{1'b0}};
            inflight_last_q <= 1'b0;
            slot0_valid_q   <= 1'b0;
            slot0_data_q    <= {OUT_WIDTH{1'b0}};
            slot0_addr_q    <= {ADDR_WIDTH{1'b0}};
            slot0_last_q    <= 1'b0;
            slot1_valid_q   <= 1'b0;
            slot1_data_q    <= {OUT_WIDTH{1'b0}};
            slot1_addr_q    <= {ADDR_WIDTH{1'b0}};
            slot1_last_q    <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            inflight_q    <= rd_en_s;
            slot0_valid_q <= slot0_valid_d;
            slot0_data_q  <= slot0_data_d;
            slot0_addr_q  <= slot0_addr_d;
            slot0_last_q  <= slot0_last_d;
            slot1_valid_q <= slot1_valid_d;
            slot1_data_q  <= slot1_data_d;
            slot1_addr_q  <= slot1_addr_d;
            slot1_last_q  <= slot1_last_d;
            if (rd_en_s) begin
                inflight_addr_q <= rd_addr_s;
                inflight_last_q <= rd_last_s;
                last_addr_q     <= rd_addr_s;
                issued_q        <= issued_q + CNT_ONE;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (count != CNT_ZERO) begin
                            base_q   <= base_addr;
                            count_q  <= count;
                            shift_q  <= shift;
                            relu_q   <= relu_en;
                            issued_q <= CNT_ZERO;
                            busy_q   <= 1'b1;
                            state_q  <= ST_READ;
                        end else begin
                            // Empty drain: acknowledge without touching memory.
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_en_s && rd_last_s) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (drain_done_s) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read port is issued combinationally so credit can track same-cycle pops.
    assign Acc_Rd_en   = rd_en_s;
    assign Acc_Rd_Addr = rd_en_s ? rd_addr_s : last_addr_q;
    assign out_valid   = slot0_valid_q;
    assign out_data    = slot0_data_q;
    assign out_addr    = slot0_addr_q;
    assign out_last    = slot0_last_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_accumulator_drain.sv
module tb_accumulator_drain;

    localparam int PSW   = 45;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int OW    = 8;
    localparam int SW    = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [AW-1:0]  base_addr;
    logic [AW:0]    count;
    logic [SW-1:0]  shift;
    logic           relu_en;
    logic           Acc_Rd_en;
    logic [AW-1:0]  Acc_Rd_Addr;
    logic [PSW-1:0] psum_r;
    logic           out_valid;
    logic           out_ready;
    logic [OW-1:0]  out_data;
    logic [AW-1:0]  out_addr;
    logic           out_last;
    logic           busy;
    logic           done;

    accumulator_drain dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .base_addr       (base_addr),
        .count           (count),
        .shift           (shift),
        .relu_en         (relu_en),
        .Acc_Rd_en       (Acc_Rd_en),
        .Acc_Rd_Addr     (Acc_Rd_Addr),
        .Partial_Sum_out (psum_r),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_addr        (out_addr),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] data;
        logic [AW-1:0] addr;
        logic          last;
    } beat_t;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int ready_mode = 0;

    logic signed [PSW-1:0] mem [DEPTH];
    beat_t          exp_q[$];
    logic [AW-1:0]  exp_rd_q[$];
    logic [OW-1:0]  beat_log[$];
    int done_due = -1;
    int zero_due = -1;
    int outstanding = 0;
    int accepted_total = 0;
    int first_rd = -1;
    int first_vld = -1;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    beat_t         prev_beat;
    logic [AW-1:0] prev_addr = '0;

    // Accumulator memory with a registered read port.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (Acc_Rd_en) psum_r <= mem[Acc_Rd_Addr];
    end

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference requantizer: floor division by 2^sh via 64-bit shift, then clamp.
    function automatic logic [OW-1:0] ref_quant(input logic signed [PSW-1:0] v,
                                                input int sh, input bit relu);
        longint x;
        longint s;
        x = v;
        s = x >>> sh;
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return 8'(s);
    endfunction

    // Consumer readiness pattern.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Per-cycle compare process against the expected read/beat streams.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_addr  = '0;
                exp_q.delete();
                exp_rd_q.delete();
                outstanding = 0;
                done_due = -1;
            end else begin
                check("done", done, (cyc == done_due) || (cyc == zero_due));
                if (Acc_Rd_en) begin
                    if (first_rd < 0) first_rd = cyc;
                    outstanding++;
                    if (exp_rd_q.size() == 0) check("spurious_read", 1, 0);
                    else check("rd_addr", Acc_Rd_Addr, exp_rd_q.pop_front());
                end else begin
                    check("rd_addr_hold", Acc_Rd_Addr, prev_addr);
                end
                prev_addr = Acc_Rd_Addr;
                if (out_valid && first_vld < 0) first_vld = cyc;
                if (prev_valid && !prev_ready) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_beat", {out_data, out_addr, out_last}, prev_beat);
                end
                if (out_valid && out_ready) begin
                    beat_t e;
                    accepted_total++;
                    outstanding--;
                    beat_log.push_back(out_data);
                    if (exp_q.size() == 0) begin
                        check("spurious_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", $signed(out_data), $signed(e.data));
                        check("out_addr", out_addr, e.addr);
                        check("out_last", out_last, e.last);
                        if (e.last) done_due = cyc + 1;
                    end
                end
                if (Acc_Rd_en) check("outstanding_le2", outstanding <= 2, 1);
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_beat  = {out_data, out_addr, out_last};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int b, input int c, input int sh, input bit relu);
        beat_t e;
        for (int i = 0; i < c; i++) begin
            int a;
            a = (b + i) % DEPTH;
            exp_rd_q.push_back(AW'(a));
            e.data = ref_quant(mem[a], sh, relu);
            e.addr = AW'(a);
            e.last = (i == c - 1);
            exp_q.push_back(e);
        end
        if (c == 0) zero_due = cyc + 1;
        beat_log.delete();
        first_rd  = -1;
        first_vld = -1;
        base_addr = AW'(b);
        count     = (AW + 1)'(c);
        shift     = SW'(sh);
        relu_en   = relu;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, c != 0);
    endtask

    task automatic wait_done(input int c);
        int n;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        check("done_within_bound", n < 400, 1);
        check("busy_at_done", busy, 0);
        if (c != 0) check("first_valid_latency", first_vld - first_rd, 2);
        tick();
        check("model_drained", exp_q.size() + exp_rd_q.size(), 0);
    endtask

    task automatic check_reset_vals();
        check("rst_rd_en", Acc_Rd_en, 0);
        check("rst_rd_addr", Acc_Rd_Addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            logic [63:0] r;
            int v;
            r = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0: mem[i] = r[PSW-1:0];
                1: begin v = int'($urandom_range(0, 4000)) - 2000; mem[i] = PSW'(v); end
                default: begin v = int'($urandom); mem[i] = PSW'(v); end
            endcase
        end
    endtask

    initial begin
        int lit_a[4];
        int lit_b[3];
        int lit_c[3];
        int target;
        lit_a = '{25, -75, 127, -1};
        lit_b = '{0, 127, 7};
        lit_c = '{-128, 127, 7};
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; shift = '0; relu_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (3) tick();
        check_reset_vals();
        rst = 1'b0;
        tick();

        // Basic drain with hand-computed results.
        mem[0] = 45'sd100; mem[1] = -45'sd300; mem[2] = 45'sd1000; mem[3] = -45'sd1;
        launch(0, 4, 2, 1'b0);
        wait_done(4);
        check("basic_n", beat_log.size(), 4);
        for (int i = 0; i < 4 && i < beat_log.size(); i++) check("basic_beat", $signed(beat_log[i]), lit_a[i]);

        // ReLU and saturation.
        mem[0] = -45'sd5000; mem[1] = 45'sd40000; mem[2] = 45'sd7;
        launch(0, 3, 0, 1'b1);
        wait_done(3);
        check("relu_n", beat_log.size(), 3);
        for (int i = 0; i < 3 && i < beat_log.size(); i++) check("relu_beat", $signed(beat_log[i]), lit_b[i]);
        launch(0, 3, 0, 1'b0);
        wait_done(3);
        check("sat_n", beat_log.size(), 3);
        for (int i = 0; i < 3 && i < beat_log.size(); i++) check("sat_beat", $signed(beat_log[i]), lit_c[i]);

        // Wrap with a 6-cycle backpressure window.
        fill_random();
        launch(6, 4, 3, 1'b0);
        tick();
        ready_mode = 2;
        repeat (6) tick();
        ready_mode = 0;
        wait_done(4);
        check("wrap_n", beat_log.size(), 4);

        // Edge counts.
        launch(0, 0, 0, 1'b0);
        wait_done(0);
        ready_mode = 1;
        fill_random();
        launch(3, 8, 1, 1'b0);
        wait_done(8);
        check("full_n", beat_log.size(), 8);

        // Reset mid-drain, then a fresh drain.
        ready_mode = 0;
        target = accepted_total + 2;
        launch(0, 8, 0, 1'b0);
        for (int n = 0; n < 100 && accepted_total < target; n++) tick();
        check("two_beats_seen", accepted_total >= target, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals();
        repeat (4) tick();
        launch(1, 5, 2, 1'b1);
        wait_done(5);

        // Start while busy must be ignored.
        ready_mode = 1;
        fill_random();
        launch(2, 6, 1, 1'b0);
        tick();
        base_addr = 3'd5; count = 4'd3; shift = 6'd4; relu_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(6);
        check("busy_start_n", beat_log.size(), 6);

        // Randomized drains.
        for (int k = 0; k < 40; k++) begin
            int c, b, sh;
            fill_random();
            ready_mode = $urandom_range(0, 1);
            c  = $urandom_range(0, 8);
            b  = $urandom_range(0, 7);
            sh = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 16);
            launch(b, c, sh, 1'($urandom_range(0, 1)));
            wait_done(c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/accumulator_drain.md
Name: accumulator_drain

Overview:
Read-side controller for the partial-sum accumulator memory. On `start` it walks a programmed range of accumulator addresses and drives the accumulator's read-enable/read-address port. It captures each registered read result, requantizes it (arithmetic shift, optional ReLU, saturation) and streams the results out over a valid/ready interface. A 2-entry output buffer absorbs the accumulator's 1-cycle read latency, so backpressure loses no data.

Parameters:
- SIZE, 8: systolic array dimension, kept consistent with the accumulator.
- PARTIAL_SUM_WIDTH, 45: width of a signed partial sum, ((8*4)+4)+SIZE+1.
- DEPTH, 8: number of accumulator entries.
- ADDR_WIDTH, 3: accumulator address width, log2(DEPTH).
- OUT_WIDTH, 8: width of the signed requantized output.
- SHIFT_WIDTH, 6: width of the shift amount.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins a drain when idle, ignored while busy.
- base_addr  in  ADDR_WIDTH  first address to read; latched at start.
- count  in  ADDR_WIDTH+1  number of entries to read, 0..DEPTH; latched at start.
- shift  in  SHIFT_WIDTH  arithmetic right-shift amount; latched at start.
- relu_en  in  1  clamp negative results to 0; latched at start.
- Acc_Rd_en  out  1  accumulator read enable.
- Acc_Rd_Addr  out  ADDR_WIDTH  accumulator read address.
- Partial_Sum_out  in  PARTIAL_SUM_WIDTH  signed registered read data from the accumulator; valid the cycle after Acc_Rd_en.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  OUT_WIDTH  signed requantized value.
- out_addr  out  ADDR_WIDTH  source accumulator address of the beat.
- out_last  out  1  final beat of the drain.
- busy  out  1  drain in progress.
- done  out  1  1-cycle pulse after the last beat is accepted.

Behaviour:
- Reset values: Acc_Rd_en=0, Acc_Rd_Addr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0, done=0. The buffer is emptied, the in-flight flag cleared and the FSM set to IDLE.
- Reset during a drain aborts it immediately. No done pulse is generated and no further reads are issued.
- FSM states:
  - IDLE: on start with count!=0, latch the config, set busy=1 and go to READ. On start with count==0, pulse done on the next cycle, issue no reads and stay in IDLE.
  - READ: issue one read per cycle while credit is available. After the count-th read is issued, go to FLUSH.
  - FLUSH: wait until the in-flight read has landed and the buffer is empty with its last beat accepted. Then pulse done, clear busy and go to IDLE.
- Read addressing: the address for read i is (base_addr + i) mod DEPTH, so the range wraps past DEPTH-1 to 0.
- Credit rule: a read may issue in cycle t only if (buffer occupancy + in-flight reads) < 2. Occupancy counts entries after this cycle's pop, so pop and issue can happen in the same cycle.
- Read latency:
  - The read issued in cycle t is sampled on Partial_Sum_out in cycle t+1 and written into the buffer at the end of t+1.
  - The earliest out_valid is in cycle t+2.
  - With out_ready held high, steady-state throughput is 1 beat/cycle.
- Beat tagging: each buffer entry carries its data, its address, and a last flag set on the count-th read.
- Requantization, applied at buffer write:
  - s = Partial_Sum_out >>> shift (sign-extending, truncation toward -inf).
  - If relu_en and s<0, then s=0.
  - Saturate s to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - A shift >= PARTIAL_SUM_WIDTH gives 0 for non-negative inputs and -1 for negative inputs.
- Handshake:
  - out_valid stays asserted and out_data/out_addr/out_last stay stable until out_valid&&out_ready.
  - Output is in-order FIFO.
  - Push and pop in the same cycle with the buffer full is legal: occupancy is unchanged and no data is lost.
- Config changes: start, base_addr, count, shift and relu_en are ignored while busy=1.
- Output discipline: Acc_Rd_en is asserted only while in READ. Acc_Rd_Addr holds its last value when Acc_Rd_en=0.

Test Plan:
- Basic drain: entries 0..3 = {100, -300, 1000, -1}, base=0, count=4, shift=2, relu=0, out_ready=1 -> beats 25, -75, 127 (saturated), -1 on addrs 0..3. out_last is set on addr 3; done pulses exactly 1 cycle after that beat; first out_valid arrives 2 cycles after the first Acc_Rd_en.
- ReLU and saturation: entries {-5000, 40000, 7}, shift=0, relu=1 -> beats 0, 127, 7. With relu=0 the same entries give -128, 127, 7.
- Wrap and backpressure: base=6, count=4 -> reads addrs 6, 7, 0, 1. With out_ready low for 6 cycles mid-drain, at most 2 reads are outstanding or buffered, and all 4 beats arrive in order with no duplicates or loss.
- Edge counts: count=0 -> no Acc_Rd_en, done pulse 1 cycle after start. count=8, base=3 -> all 8 addresses read exactly once.
- Reset mid-drain: assert rst after 2 beats of a count=8 drain -> next cycle all outputs are at reset values with no done pulse. A fresh start then drains correctly.
- Start while busy: pulse start with different base/count/shift during a drain -> ignored; the original drain completes unchanged.
